// File: rtl/uart_prog_loader_if.sv
// Bundles the UART byte stream, instruction-memory write port and loader status
// that connect uart_prog_loader to the rest of the system.
interface uart_prog_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_err;

    // The loader consumes bytes and drives memory writes and status.
    modport master (
        input  rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
    );

    // The environment supplies bytes and observes writes and status.
    modport slave (
        output rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/uart_prog_loader.sv
// Parses MAGIC/LEN/payload/CSUM packets from a UART byte stream, writes little-endian words
// into instruction memory and holds the CPU in reset until a load completes cleanly.
module uart_prog_loader #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter logic [7:0]  MAGIC        = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 2_600_000
) (
    input logic                clk,
    input logic                rst,
    uart_prog_loader_if.master bus
);
    localparam int unsigned         TmoWidth = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TmoWidth-1:0] TmoLast  = TmoWidth'(TIMEOUT_CLKS - 1);
    localparam logic [31:0]         MaxWords = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StData, StCsum, StDone, StErr
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    // One extra bit so a full-memory load ends at 2^ADDR_WIDTH instead of wrapping.
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [7:0]            sum_q, sum_d;
    logic [23:0]           word_q, word_d;
    logic [TmoWidth-1:0]   tmo_q, tmo_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;

    logic [15:0] len_new;
    logic        last_word;
    logic        in_packet;

    assign len_new   = {bus.rx_data, len_q[7:0]};
    assign last_word = (17'(word_idx_q) + 17'd1) == {1'b0, len_q};
    assign in_packet = (state_q == StLenLo) || (state_q == StLenHi) ||
                       (state_q == StData)  || (state_q == StCsum);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            len_q        <= '0;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            sum_q        <= '0;
            word_q       <= '0;
            tmo_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            sum_q        <= sum_d;
            word_q       <= word_d;
            tmo_q        <= tmo_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        sum_d        = sum_q;
        word_d       = word_q;
        tmo_d        = '0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;

        if (bus.rx_valid) begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (bus.rx_data == MAGIC) begin
                        state_d     = StLenLo;
                        cpu_hold_d  = 1'b1;
                        load_done_d = 1'b0;
                        load_err_d  = 1'b0;
                        byte_idx_d  = '0;
                        word_idx_d  = '0;
                        sum_d       = '0;
                    end
                end
                StLenLo: begin
                    len_d   = {8'h00, bus.rx_data};
                    state_d = StLenHi;
                end
                StLenHi: begin
                    len_d = len_new;
                    if (32'(len_new) > MaxWords) begin
                        state_d    = StErr;
                        cpu_hold_d = 1'b1;
                        load_err_d = 1'b1;
                    end else if (len_new == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    sum_d      = sum_q + bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    unique case (byte_idx_q)
                        2'd0: word_d[7:0]   = bus.rx_data;
                        2'd1: word_d[15:8]  = bus.rx_data;
                        2'd2: word_d[23:16] = bus.rx_data;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                            imem_wdata_d = {bus.rx_data, word_q};
                            word_idx_d   = word_idx_q + 1'b1;
                            if (last_word) begin
                                state_d = StCsum;
                            end
                        end
                    endcase
                end
                StCsum: begin
                    if (bus.rx_data == sum_q) begin
                        state_d     = StDone;
                        cpu_hold_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = StErr;
                        cpu_hold_d = 1'b1;
                        load_err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (in_packet) begin
            // A byte on the terminal-count cycle takes the branch above instead.
            if (tmo_q == TmoLast) begin
                state_d    = StErr;
                cpu_hold_d = 1'b1;
                load_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TmoWidth'(1);
            end
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader (ADDR_WIDTH=4, TIMEOUT_CLKS=100); writes are logged
// on the falling edge and compared against hand-computed words.
module tb_uart_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [3:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    uart_prog_loader_if #(.ADDR_WIDTH(4)) bus ();

    uart_prog_loader #(
        .ADDR_WIDTH  (4),
        .MAGIC       (8'hA5),
        .TIMEOUT_CLKS(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Sends the low n bytes of v, most significant first, back to back.
    task automatic send_vec(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) drive_byte(v[8*(n-1-i) +: 8]);
        idle();
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.cpu_hold !== 1'b1) begin bad++; $display("FAIL reset_hold got %b want 1", bus.cpu_hold); end
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.load_done); end
        total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", bus.load_err); end
        total++; if (bus.imem_we !== 1'b0) begin bad++; $display("FAIL reset_we got %b want 0", bus.imem_we); end
        total++; if (bus.imem_addr !== 4'h0) begin bad++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
        total++; if (bus.imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got %h want 0", bus.imem_wdata); end
    endtask

    // Payload sum 0x78+0x56+0x34+0x12+0xEF+0xBE+0xAD+0xDE = 0x44C, so CSUM is 0x4C.
    task automatic test_valid();
        clear_log();
        send_vec(96'hA5_02_00_78_56_34_12_EF_BE_AD_DE_4C, 12);
        total++; if (wr_addr.size() !== 2) begin bad++; $display("FAIL valid_nwrites got %0d want 2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            total++; if (wr_addr[0] !== 4'h0) begin bad++; $display("FAIL valid_addr0 got %h want 0", wr_addr[0]); end
            total++; if (wr_data[0] !== 32'h12345678) begin bad++; $display("FAIL valid_data0 got %h want 12345678", wr_data[0]); end
            total++; if (wr_addr[1] !== 4'h1) begin bad++; $display("FAIL valid_addr1 got %h want 1", wr_addr[1]); end
            total++; if (wr_data[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL valid_data1 got %h want deadbeef", wr_data[1]); end
        end
        total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL valid_done got %b want 1", bus.load_done); end
        total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL valid_hold got %b want 0", bus.cpu_hold); end
        total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL valid_err got %b want 0", bus.load_err); end
    endtask

    task automatic test_bad_csum();
        clear_log();
        send_vec(96'hA5_02_00_78_56_34_12_EF_BE_AD_DE_3B, 12);
        total++; if (wr_addr.size() !== 2) begin bad++; $display("FAIL badcs_nwrites got %0d want 2", wr_addr.size()); end
        total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL badcs_err got %b want 1", bus.load_err); end
        total++; if (bus.cpu_hold !== 1'b1) begin bad++; $display("FAIL badcs_hold got %b want 1", bus.cpu_hold); end
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL badcs_done got %b want 0", bus.load_done); end
    endtask

    task automatic test_garbage_zero_len();
        clear_log();
        send_vec(48'h00_FF_A5_00_00_00, 6);
        total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL zlen_nwrites got %0d want 0", wr_addr.size()); end
        total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL zlen_done got %b want 1", bus.load_done); end
        total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL zlen_hold got %b want 0", bus.cpu_hold); end
        send_vec(32'hA5_00_00_01, 4);
        total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL zlen_badcs_err got %b want 1", bus.load_err); end
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL zlen_badcs_done got %b want 0", bus.load_done); end
    endtask

    // 64 payload bytes 0..63: word k = {4k+3, 4k+2, 4k+1, 4k}; sum 2016 mod 256 = 0xE0.
    task automatic test_overflow();
        logic [31:0] exp_w;
        clear_log();
        send_vec(24'hA5_11_00, 3);
        total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL ovf_err got %b want 1", bus.load_err); end
        total++; if (bus.cpu_hold !== 1'b1) begin bad++; $display("FAIL ovf_hold got %b want 1", bus.cpu_hold); end
        total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL ovf_nwrites got %0d want 0", wr_addr.size()); end
        drive_byte(8'hA5);
        drive_byte(8'h10);
        drive_byte(8'h00);
        for (int j = 0; j < 64; j++) drive_byte(8'(j));
        drive_byte(8'hE0);
        idle();
        total++; if (wr_addr.size() !== 16) begin bad++; $display("FAIL full_nwrites got %0d want 16", wr_addr.size()); end
        for (int k = 0; k < 16; k++) begin
            if (k < wr_addr.size()) begin
                exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
                total++; if (wr_addr[k] !== 4'(k)) begin bad++; $display("FAIL full_addr%0d got %h want %h", k, wr_addr[k], 4'(k)); end
                total++; if (wr_data[k] !== exp_w) begin bad++; $display("FAIL full_data%0d got %h want %h", k, wr_data[k], exp_w); end
            end
        end
        total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL full_done got %b want 1", bus.load_done); end
        total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL full_err got %b want 0", bus.load_err); end
    endtask

    task automatic test_timeout();
        send_vec(40'hA5_01_00_11_22, 5);
        // The last byte was taken on edge k; edges k+1..k+99 count 0..99 with no byte.
        repeat (99) @(negedge clk);
        total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL tmo_early got %b want 0", bus.load_err); end
        @(negedge clk);
        total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL tmo_err got %b want 1", bus.load_err); end
        total++; if (bus.cpu_hold !== 1'b1) begin bad++; $display("FAIL tmo_hold got %b want 1", bus.cpu_hold); end

        clear_log();
        send_vec(40'hA5_01_00_11_22, 5);
        repeat (98) @(negedge clk);
        drive_byte(8'h33);  // sampled on the terminal-count cycle
        idle();
        total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL tmo_edge_err got %b want 0", bus.load_err); end
        send_vec(16'h44_AA, 2);
        total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL tmo_edge_done got %b want 1", bus.load_done); end
        total++; if (wr_data.size() !== 1) begin bad++; $display("FAIL tmo_edge_nwrites got %0d want 1", wr_data.size()); end
        if (wr_data.size() == 1) begin
            total++; if (wr_data[0] !== 32'h44332211) begin bad++; $display("FAIL tmo_edge_data got %h want 44332211", wr_data[0]); end
        end
    endtask

    task automatic test_reset_mid();
        send_vec(40'hA5_01_00_AA_BB, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.cpu_hold !== 1'b1) begin bad++; $display("FAIL rmid_hold got %b want 1", bus.cpu_hold); end
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL rmid_done got %b want 0", bus.load_done); end
        total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL rmid_err got %b want 0", bus.load_err); end
        total++; if (bus.imem_wdata !== 32'h0) begin bad++; $display("FAIL rmid_wdata got %h want 0", bus.imem_wdata); end
        total++; if (bus.imem_addr !== 4'h0) begin bad++; $display("FAIL rmid_addr got %h want 0", bus.imem_addr); end
        clear_log();
        send_vec(96'hA5_02_00_78_56_34_12_EF_BE_AD_DE_4C, 12);
        total++; if (wr_addr.size() !== 2) begin bad++; $display("FAIL rmid_nwrites got %0d want 2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            total++; if (wr_addr[0] !== 4'h0) begin bad++; $display("FAIL rmid_addr0 got %h want 0", wr_addr[0]); end
            total++; if (wr_data[0] !== 32'h12345678) begin bad++; $display("FAIL rmid_data0 got %h want 12345678", wr_data[0]); end
        end
        total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL rmid_load_done got %b want 1", bus.load_done); end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        test_reset();
        test_valid();
        test_bad_csum();
        test_garbage_zero_len();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
